syncmem_2p_param: RTL and testbench

- Parametrised true dual-port synchronous RAM. Successor to the fixed 256x16 two-port memory used by the Basic CPU.
- Adds configurable width and depth, byte-enables, registered read data with valid flags, and a defined read-during-write mode.
- Adds write-collision arbitration with a flag, and a hardware clear sweep with BUSY.
- Sits between the CPU datapath (port 0, instruction/data) and a loader/debug master (port 1).

---
 rtl/syncmem_2p_param.sv | 142 ++++++++++++++
 tb/tb_syncmem_2p_param.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/syncmem_2p_param.sv
// True dual-port synchronous RAM with byte enables, registered read data, collision flag and
// a hardware zero-fill sweep. Define SYNCMEM_PARITY_EN to add per-word even parity and PERR.
module syncmem_2p_param #(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 8,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  output logic          busy,
  input  logic          en0,
  input  logic          we0,
  input  logic [DW/8-1:0] be0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wd0,
  output logic [DW-1:0] rd0,
  output logic          rvalid0,
  input  logic          en1,
  input  logic          we1,
  input  logic [DW/8-1:0] be1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd1,
  output logic [DW-1:0] rd1,
  output logic          rvalid1,
`ifdef SYNCMEM_PARITY_EN
  output logic          perr0,
  output logic          perr1,
`endif
  output logic          coll
);

  localparam int unsigned NB    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [AW:0] LAST  = (AW + 1)'(DEPTH - 1);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e        state_q;
  logic [AW:0]   cnt_q;
  logic [DW-1:0] mem [DEPTH];

  logic          idle, acc0, acc1, w0, w1, same;
  logic [DW-1:0] old0, old1, new0, new1;

  assign idle = (state_q == StIdle);
  assign acc0 = idle & en0;
  assign acc1 = idle & en1;
  assign w0   = acc0 & we0;
  assign w1   = acc1 & we1;
  assign same = (addr0 == addr1);

  // Post-write word seen at each port's address: port 1 bytes first, port 0 bytes override.
  always_comb begin
    old0 = mem[addr0];
    old1 = mem[addr1];
    new0 = old0;
    new1 = old1;
    for (int unsigned b = 0; b < NB; b++) begin
      if (w1 && be1[b]) begin
        new1[b*8 +: 8] = wd1[b*8 +: 8];
        if (same) new0[b*8 +: 8] = wd1[b*8 +: 8];
      end
      if (w0 && be0[b]) begin
        new0[b*8 +: 8] = wd0[b*8 +: 8];
        if (same) new1[b*8 +: 8] = wd0[b*8 +: 8];
      end
    end
  end

`ifdef SYNCMEM_PARITY_EN
  logic par_mem [DEPTH];
  logic hit0, hit1, par0, par1;

  assign hit0 = w0 | (w1 & same);
  assign hit1 = w1 | (w0 & same);
  // Stored parity matching the word each port returns this cycle.
  assign par0 = (RDW_MODE != 0 && hit0) ? ^new0 : par_mem[addr0];
  assign par1 = (RDW_MODE != 0 && hit1) ? ^new1 : par_mem[addr1];
`endif

  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem[cnt_q[AW-1:0]] <= '0;
`ifdef SYNCMEM_PARITY_EN
      par_mem[cnt_q[AW-1:0]] <= 1'b0;
`endif
    end else begin
      if (w1) mem[addr1] <= new1;
      if (w0) mem[addr0] <= new0;
`ifdef SYNCMEM_PARITY_EN
      if (w1) par_mem[addr1] <= ^new1;
      if (w0) par_mem[addr0] <= ^new0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy    <= 1'b0;
      rd0     <= '0;
      rd1     <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      coll    <= 1'b0;
`ifdef SYNCMEM_PARITY_EN
      perr0   <= 1'b0;
      perr1   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (init) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy    <= 1'b1;
          end
        end
        StClear: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
      endcase

      rvalid0 <= acc0;
      rvalid1 <= acc1;
      if (acc0) rd0 <= (RDW_MODE != 0) ? new0 : old0;
      if (acc1) rd1 <= (RDW_MODE != 0) ? new1 : old1;
      coll <= w0 & w1 & same;
`ifdef SYNCMEM_PARITY_EN
      if (acc0) perr0 <= ((RDW_MODE != 0) ? ^new0 : ^old0) ^ par0;
      if (acc1) perr1 <= ((RDW_MODE != 0) ? ^new1 : ^old1) ^ par1;
`endif
    end
  end

endmodule

// File: tb/tb_syncmem_2p_param.sv
// Bench for syncmem_2p_param: a read-old and a read-new instance share stimulus; table vectors
// plus hand sequences for the sweep, mid-sweep reset and (optionally) parity.
module tb_syncmem_2p_param;

  logic        clk = 1'b0;
  logic        rst_n, init;
  logic        en0, we0, en1, we1;
  logic [1:0]  be0, be1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wd0, wd1;
  logic        busy_a, busy_b, rv0_a, rv0_b, rv1_a, rv1_b, coll_a, coll_b;
  logic [15:0] rd0_a, rd0_b, rd1_a, rd1_b;
`ifdef SYNCMEM_PARITY_EN
  logic        perr0_a, perr1_a, perr0_b, perr1_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  syncmem_2p_param #(.DW(16), .AW(8), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .init(init), .busy(busy_a),
    .en0(en0), .we0(we0), .be0(be0), .addr0(addr0), .wd0(wd0), .rd0(rd0_a), .rvalid0(rv0_a),
    .en1(en1), .we1(we1), .be1(be1), .addr1(addr1), .wd1(wd1), .rd1(rd1_a), .rvalid1(rv1_a),
`ifdef SYNCMEM_PARITY_EN
    .perr0(perr0_a), .perr1(perr1_a),
`endif
    .coll(coll_a)
  );

  syncmem_2p_param #(.DW(16), .AW(8), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .init(init), .busy(busy_b),
    .en0(en0), .we0(we0), .be0(be0), .addr0(addr0), .wd0(wd0), .rd0(rd0_b), .rvalid0(rv0_b),
    .en1(en1), .we1(we1), .be1(be1), .addr1(addr1), .wd1(wd1), .rd1(rd1_b), .rvalid1(rv1_b),
`ifdef SYNCMEM_PARITY_EN
    .perr0(perr0_b), .perr1(perr1_b),
`endif
    .coll(coll_b)
  );

  typedef struct {
    logic        en0, we0;
    logic [1:0]  be0;
    logic [7:0]  a0;
    logic [15:0] wd0;
    logic        en1, we1;
    logic [1:0]  be1;
    logic [7:0]  a1;
    logic [15:0] wd1;
    logic        rv0;
    logic [15:0] rd0_o, rd0_n;
    logic        rv1;
    logic [15:0] rd1_o, rd1_n;
    logic        coll;
  } vec_t;

  vec_t tbl[16];
  vec_t sb[$];

  function automatic vec_t mk(input int e0, input int w0, input int b0, input int a0,
                              input int d0, input int e1, input int w1, input int b1,
                              input int a1, input int d1, input int rv0, input int r0o,
                              input int r0n, input int rv1, input int r1o, input int r1n,
                              input int cl);
    vec_t v;
    v.en0 = 1'(e0);  v.we0 = 1'(w0);  v.be0 = 2'(b0);  v.a0 = 8'(a0);  v.wd0 = 16'(d0);
    v.en1 = 1'(e1);  v.we1 = 1'(w1);  v.be1 = 2'(b1);  v.a1 = 8'(a1);  v.wd1 = 16'(d1);
    v.rv0 = 1'(rv0); v.rd0_o = 16'(r0o); v.rd0_n = 16'(r0n);
    v.rv1 = 1'(rv1); v.rd1_o = 16'(r1o); v.rd1_n = 16'(r1n);
    v.coll = 1'(cl);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    init = 1'b0;
    en0 = 1'b0; we0 = 1'b0; be0 = '0; addr0 = '0; wd0 = '0;
    en1 = 1'b0; we1 = 1'b0; be1 = '0; addr1 = '0; wd1 = '0;
  endtask

  task automatic idle_cycles(input int n);
    drive_idle();
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    en0 = v.en0; we0 = v.we0; be0 = v.be0; addr0 = v.a0; wd0 = v.wd0;
    en1 = v.en1; we1 = v.we1; be1 = v.be1; addr1 = v.a1; wd1 = v.wd1;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("rvalid0_old", 32'(rv0_a), 32'(e.rv0));
    chk("rvalid0_new", 32'(rv0_b), 32'(e.rv0));
    chk("rd0_old", 32'(rd0_a), 32'(e.rd0_o));
    chk("rd0_new", 32'(rd0_b), 32'(e.rd0_n));
    chk("rvalid1_old", 32'(rv1_a), 32'(e.rv1));
    chk("rvalid1_new", 32'(rv1_b), 32'(e.rv1));
    chk("rd1_old", 32'(rd1_a), 32'(e.rd1_o));
    chk("rd1_new", 32'(rd1_b), 32'(e.rd1_n));
    chk("coll_old", 32'(coll_a), 32'(e.coll));
    chk("coll_new", 32'(coll_b), 32'(e.coll));
    drive_idle();
  endtask

  initial begin
    int cnt;
    //            en we be addr wd      en we be addr wd       rv rd_old rd_new  rv rd_old rd_new  coll
    tbl[0]  = mk(1, 0, 0, 'h00, 0,      1, 0, 0, 'h7F, 0,      1, 0,      0,      1, 0,      0,      0);
    tbl[1]  = mk(1, 0, 0, 'hFF, 0,      0, 0, 0, 0,    0,      1, 0,      0,      0, 0,      0,      0);
    tbl[2]  = mk(1, 1, 3, 'h10, 'hBEEF, 0, 0, 0, 0,    0,      1, 0,      'hBEEF, 0, 0,      0,      0);
    tbl[3]  = mk(1, 1, 1, 'h10, 'h1234, 0, 0, 0, 0,    0,      1, 'hBEEF, 'hBE34, 0, 0,      0,      0);
    tbl[4]  = mk(0, 0, 0, 0,    0,      1, 0, 0, 'h10, 0,      0, 'hBEEF, 'hBE34, 1, 'hBE34, 'hBE34, 0);
    tbl[5]  = mk(1, 1, 3, 'h20, 'h1111, 0, 0, 0, 0,    0,      1, 0,      'h1111, 0, 'hBE34, 'hBE34, 0);
    tbl[6]  = mk(1, 1, 3, 'h20, 'h2222, 1, 0, 0, 'h20, 0,      1, 'h1111, 'h2222, 1, 'h1111, 'h2222, 0);
    tbl[7]  = mk(0, 0, 0, 0,    0,      1, 0, 0, 'h20, 0,      0, 'h1111, 'h2222, 1, 'h2222, 'h2222, 0);
    tbl[8]  = mk(1, 1, 2, 'h30, 'hAAAA, 1, 1, 3, 'h30, 'h5555, 1, 0,      'hAA55, 1, 0,      'hAA55, 1);
    tbl[9]  = mk(1, 0, 0, 'h30, 0,      1, 0, 0, 'h30, 0,      1, 'hAA55, 'hAA55, 1, 'hAA55, 'hAA55, 0);
    tbl[10] = mk(1, 1, 0, 'h40, 'hFFFF, 1, 1, 3, 'h40, 'h1234, 1, 0,      'h1234, 1, 0,      'h1234, 1);
    tbl[11] = mk(1, 1, 3, 'h41, 'h5678, 1, 1, 1, 'h42, 'h9ABC, 1, 0,      'h5678, 1, 0,      'h00BC, 0);
    tbl[12] = mk(1, 0, 0, 'h42, 0,      1, 0, 0, 'h41, 0,      1, 'h00BC, 'h00BC, 1, 'h5678, 'h5678, 0);
    tbl[13] = mk(1, 1, 0, 'h41, 'hFFFF, 1, 0, 0, 'h41, 0,      1, 'h5678, 'h5678, 1, 'h5678, 'h5678, 0);
    tbl[14] = mk(1, 0, 0, 'h50, 0,      1, 1, 2, 'h50, 'hF00D, 1, 0,      'hF000, 1, 0,      'hF000, 0);
    tbl[15] = mk(1, 0, 0, 'h50, 0,      0, 0, 0, 0,    0,      1, 'hF000, 'hF000, 0, 0,      'hF000, 0);

    drive_idle();
    rst_n = 1'b0;
    #1;
    chk("reset_busy", 32'(busy_a | busy_b), 32'(0));
    chk("reset_rvalid", 32'({rv0_a, rv1_a, rv0_b, rv1_b}), 32'(0));
    chk("reset_rd", 32'(rd0_a | rd1_a | rd0_b | rd1_b), 32'(0));
    chk("reset_coll", 32'(coll_a | coll_b), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full sweep; a second INIT mid-sweep must not restart it.
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    cnt = 0;
    while (busy_a && busy_b && cnt < 1000) begin
      cnt++;
      if (cnt == 10) init = 1'b1;
      @(posedge clk);
      #1;
      init = 1'b0;
    end
    chk("sweep_busy_cycles", 32'(cnt), 32'(256));
    chk("sweep_busy_low", 32'(busy_a | busy_b), 32'(0));

    for (int i = 0; i < 16; i++) apply(tbl[i]);

    // Access in the INIT cycle completes; accesses during the sweep are dropped.
    apply(mk(1, 1, 3, 'hF0, 'hCAFE, 0, 0, 0, 0, 0, 1, 0, 'hCAFE, 0, 0, 'hF000, 0));
    init = 1'b1;
    apply(mk(1, 0, 0, 'hF0, 0, 0, 0, 0, 0, 0, 1, 'hCAFE, 'hCAFE, 0, 0, 'hF000, 0));
    chk("init_busy", 32'({busy_a, busy_b}), 32'(3));
    idle_cycles(98);
    apply(mk(1, 1, 3, 'h05, 'h7777, 1, 0, 0, 'h05, 0, 0, 'hCAFE, 'hCAFE, 0, 0, 'hF000, 0));
    idle_cycles(49);
    chk("clear_busy", 32'({busy_a, busy_b}), 32'(3));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midsweep_reset_busy", 32'(busy_a | busy_b), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk(1, 0, 0, 'h00, 0, 1, 0, 0, 'hF0, 0, 1, 0, 0, 1, 'hCAFE, 'hCAFE, 0));
    apply(mk(1, 0, 0, 'h05, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'hCAFE, 'hCAFE, 0));
    chk("post_reset_busy", 32'(busy_a | busy_b), 32'(0));

`ifdef SYNCMEM_PARITY_EN
    apply(mk(1, 1, 3, 'h60, 'h00FF, 0, 0, 0, 0, 0, 1, 0, 'h00FF, 0, 'hCAFE, 'hCAFE, 0));
    apply(mk(1, 1, 3, 'h61, 'h00FF, 0, 0, 0, 0, 0, 1, 0, 'h00FF, 0, 'hCAFE, 'hCAFE, 0));
    dut_a.mem[8'h60][0] = ~dut_a.mem[8'h60][0];
    dut_b.mem[8'h60][0] = ~dut_b.mem[8'h60][0];
    apply(mk(1, 0, 0, 'h60, 0, 0, 0, 0, 0, 0, 1, 'h00FE, 'h00FE, 0, 'hCAFE, 'hCAFE, 0));
    chk("perr_flipped", 32'({perr0_a, perr0_b}), 32'(3));
    apply(mk(1, 0, 0, 'h61, 0, 0, 0, 0, 0, 0, 1, 'h00FF, 'h00FF, 0, 'hCAFE, 'hCAFE, 0));
    chk("perr_clean", 32'({perr0_a, perr0_b}), 32'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
